control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Fetch/decode/execute sequencer that drives the 4x4-bit register file: fetches 8-bit
//  instructions over a req/ack port, drives the read addresses, computes results in an
//  internal ALU, and issues the write-back (address/data/enable). Sits directly upstream of
//  the register file; consumes its two combinational read ports.
// PARAMETERS
//  PC_W  4  program counter / instruction address width (wraps mod 2**PC_W)
//  IW    8  instruction word width
//  DW    4  register data width
//  AW    2  register address width
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  imem_req   out  1      instruction fetch request
//  imem_addr  out  PC_W   fetch address (= pc)
//  imem_ack   in   1      fetch acknowledge; imem_data valid when req&ack
//  imem_data  in   IW     fetched word
//  rf_ra      out  AW     register read address A (rd)
//  rf_rb      out  AW     register read address B (rs)
//  rf_rd_a    in   DW     register read data A
//  rf_rd_b    in   DW     register read data B
//  rf_wa      out  AW     write-back address
//  rf_wd      out  DW     write-back data
//  rf_we      out  1      write-back enable, one-cycle pulse
//  zero_flag  out  1      Z flag
//  halted     out  1      high once HALT executed
// BEHAVIOUR
//  - Encoding ir[7:4]=op, ir[3:2]=rd, ir[1:0]=rs. 0 NOP; 1 MOV rd=rs; 2 ADD rd=rd+rs; 3 SUB rd=rd-rs;
//    4 AND; 5 OR; 6 XOR; 7 NOT rd=~rs; 8 LDI rd=imm[3:0]; 9 JMP pc=imm; A JZ pc=imm if Z; F HALT;
//    others = NOP. Ops 8/9/A take a second word (imm) at pc+1.
//  - Arithmetic mod 2**DW; carry/borrow discarded. Z <= (result==0) on ops 1-8 only.
//  - States: FETCH -> DECODE -> {FETCH_IMM ->} EXEC -> WB -> FETCH; HALT terminal.
//  - FETCH/FETCH_IMM: imem_req=1, imem_addr=pc stable until ack; on req&ack capture word,
//    pc <= pc+1 (wraps 2**PC_W-1 -> 0); ack with req=0 ignored; zero-wait ack legal.
//  - DECODE: NOP/undefined -> FETCH; HALT -> HALT; 8/9/A -> FETCH_IMM; else EXEC.
//  - FETCH_IMM: JMP pc<=imm[PC_W-1:0]; JZ taken pc<=imm, else pc+1; both -> FETCH; LDI -> EXEC.
//  - EXEC: rf_ra=rd, rf_rb=rs; ALU result and Z registered. WB: rf_we=1, rf_wa=rd,
//    rf_wd=result for exactly one cycle. ALU op zero-wait latency: 4 cycles; LDI: 5.
//  - HALT: halted=1, imem_req=0, rf_we=0 until reset.
//  - Reset (async, any state): pc=0, state FETCH, all outputs 0 (imem_req, rf_we, halted,
//    zero_flag, addresses, rf_wd); an in-flight WB is dropped immediately; first req the cycle
//    after rst_n deasserts.
// CONFIGURATION
//  SINGLE_STEP_EN defined: extra input `step` (1 bit); adds IDLE state; reset enters IDLE;
//    every path returning to FETCH goes to IDLE instead; IDLE -> FETCH when step=1 sampled.
//  Undefined: no step port, no IDLE state; free-running as above.
// STRUCTURE
//  - cpu_pkg: opcode localparams, state encodings, PC_W/IW/DW/AW defaults.
//  - Sub-module alu4: combinational (op, a, b) -> (y, zero); instantiated once.
// TESTING
//  1 LDI r1,5 (0x84,0x05), zero-wait ack -> rf_we pulse wa=1 wd=5 in 5th cycle after first req; Z=0.
//  2 r1=F, r2=1; ADD r1,r2 (0x26) -> wd=0, Z=1; then SUB r1,r2 (0x36) with r1=0 -> wd=F, Z=0.
//  3 JZ 0x3 with Z=1 -> next imem_addr=3; with Z=0 -> next addr=pc+1; NOP at pc=F -> next addr=0.
//  4 imem_ack delayed 3 cycles -> req/addr held, no rf_we, state advances only on ack.
//  5 HALT (0xF0) -> halted=1, imem_req=0 for 20 cycles; rst_n low during WB -> rf_we=0 same cycle, pc=0.
//  6 SINGLE_STEP_EN: step=0 -> no req after reset; one step pulse -> exactly one instruction retires.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: default widths, opcode values and FSM state encoding shared by control_unit
// and alu4. Optional macro SINGLE_STEP_EN adds the StIdle state.
package cpu_pkg;

   localparam int unsigned DefPcW = 4;
   localparam int unsigned DefIw  = 8;
   localparam int unsigned DefDw  = 4;
   localparam int unsigned DefAw  = 2;

   localparam logic [3:0] OpNop  = 4'h0;
   localparam logic [3:0] OpMov  = 4'h1;
   localparam logic [3:0] OpAdd  = 4'h2;
   localparam logic [3:0] OpSub  = 4'h3;
   localparam logic [3:0] OpAnd  = 4'h4;
   localparam logic [3:0] OpOr   = 4'h5;
   localparam logic [3:0] OpXor  = 4'h6;
   localparam logic [3:0] OpNot  = 4'h7;
   localparam logic [3:0] OpLdi  = 4'h8;
   localparam logic [3:0] OpJmp  = 4'h9;
   localparam logic [3:0] OpJz   = 4'hA;
   localparam logic [3:0] OpHalt = 4'hF;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StFetchImm,
      StExec,
      StWb,
      StHalt
`ifdef SINGLE_STEP_EN
      ,
      StIdle
`endif
   } state_e;

endpackage

// File: rtl/alu4.sv
// alu4: combinational ALU for control_unit. LDI passes the immediate through b so that
// the Z flag is produced the same way for every register-writing op.
module alu4
   import cpu_pkg::*;
#(
   parameter int unsigned DW = DefDw
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] y,
   output logic          zero
);

   // Result select; carry/borrow fall off the top naturally
   always_comb begin
      y = '0;
      case (op)
         OpMov:   y = b;
         OpAdd:   y = a + b;
         OpSub:   y = a - b;
         OpAnd:   y = a & b;
         OpOr:    y = a | b;
         OpXor:   y = a ^ b;
         OpNot:   y = ~b;
         OpLdi:   y = b;
         default: y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer driving a 4x4 register file.
// Optional macro SINGLE_STEP_EN: adds the `step` input and an IDLE state entered from reset
// and after every instruction; one sampled step lets exactly one instruction run.
module control_unit
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = DefPcW,
   parameter int unsigned IW   = DefIw,
   parameter int unsigned DW   = DefDw,
   parameter int unsigned AW   = DefAw
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [IW-1:0]   imem_data,
   output logic [AW-1:0]   rf_ra,
   output logic [AW-1:0]   rf_rb,
   input  logic [DW-1:0]   rf_rd_a,
   input  logic [DW-1:0]   rf_rd_b,
   output logic [AW-1:0]   rf_wa,
   output logic [DW-1:0]   rf_wd,
   output logic            rf_we,
   output logic            zero_flag,
   output logic            halted
);

`ifdef SINGLE_STEP_EN
   localparam state_e StRet   = StIdle;
   localparam state_e StReset = StIdle;
`else
   localparam state_e StRet   = StFetch;
   localparam state_e StReset = StFetch;
`endif

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc;
   logic [IW-1:0]   ir_q, ir_d;
   logic [DW-1:0]   imm_q, imm_d;
   logic [DW-1:0]   result_q, result_d;
   logic            z_q, z_d;
   // Low through reset and the first edge after it, so no request is seen during reset
   logic            run_q;

   logic [3:0]      op;
   logic            fire;
   logic [DW-1:0]   alu_b, alu_y;
   logic            alu_zero;

   assign op     = ir_q[7:4];
   assign pc_inc = pc_q + PC_W'(1);
   assign fire   = imem_req & imem_ack;
   assign alu_b  = (op == OpLdi) ? imm_q : rf_rd_b;

   alu4 #(
      .DW (DW)
   ) u_alu (
      .op   (op),
      .a    (rf_rd_a),
      .b    (alu_b),
      .y    (alu_y),
      .zero (alu_zero)
   );

   // State and datapath registers; reset drops any in-flight write-back at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StReset;
         pc_q     <= '0;
         ir_q     <= '0;
         imm_q    <= '0;
         result_q <= '0;
         z_q      <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         imm_q    <= imm_d;
         result_q <= result_d;
         z_q      <= z_d;
         run_q    <= 1'b1;
      end
   end

   // Next-state and datapath update for the fetch/decode/execute sequence
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      imm_d    = imm_q;
      result_d = result_q;
      z_d      = z_q;
      case (state_q)
         StFetch: begin
            if (fire) begin
               ir_d    = imem_data;
               pc_d    = pc_inc;
               state_d = StDecode;
            end
         end
         StDecode: begin
            case (op)
               OpMov, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNot: state_d = StExec;
               OpLdi, OpJmp, OpJz:                             state_d = StFetchImm;
               OpHalt:                                         state_d = StHalt;
               default:                                        state_d = StRet;
            endcase
         end
         StFetchImm: begin
            if (fire) begin
               imm_d = imem_data[DW-1:0];
               pc_d  = pc_inc;
               if (op == OpJmp) begin
                  pc_d    = imem_data[PC_W-1:0];
                  state_d = StRet;
               end else if (op == OpJz) begin
                  if (z_q) pc_d = imem_data[PC_W-1:0];
                  state_d = StRet;
               end else begin
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            result_d = alu_y;
            z_d      = alu_zero;
            state_d  = StWb;
         end
         StWb:   state_d = StRet;
         StHalt: state_d = StHalt;
`ifdef SINGLE_STEP_EN
         StIdle: begin
            if (step) state_d = StFetch;
         end
`endif
         default: state_d = StReset;
      endcase
   end

   assign imem_req  = run_q & ((state_q == StFetch) | (state_q == StFetchImm));
   assign imem_addr = pc_q;
   assign rf_ra     = AW'(ir_q[3:2]);
   assign rf_rb     = AW'(ir_q[1:0]);
   assign rf_wa     = AW'(ir_q[3:2]);
   assign rf_wd     = result_q;
   assign rf_we     = (state_q == StWb);
   assign zero_flag = z_q;
   assign halted    = (state_q == StHalt);

endmodule
